// File: rtl/axis_serializer_pkt.sv
// Packet-aware AXI-Stream width serializer: one wide up beat of DATA_NB words
// becomes up to DATA_NB narrow down words, in selectable order, with packet-end tagging.
module axis_serializer_pkt #(
  parameter int DATA_NB    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3,
  parameter int MSB_FIRST  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          up_ready,
  input  logic                          up_valid,
  input  logic [DATA_WIDTH*DATA_NB-1:0] up_data,
  input  logic [CNT_WIDTH-1:0]          up_cnt,
  input  logic                          up_last,
  input  logic                          down_ready,
  output logic                          down_valid,
  output logic [DATA_WIDTH-1:0]         down_data,
  output logic                          down_last
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a valid word holds data/last stable until it is taken.
  typedef enum logic [1:0] {EMPTY, LOAD, SHIFT, TAIL} state_t;

  localparam logic [CNT_WIDTH-1:0] NB_C  = CNT_WIDTH'(DATA_NB);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  rem;
  logic [CNT_WIDTH-1:0]  n_eff;
  logic [DATA_WIDTH-1:0] ord   [DATA_NB];
  logic [DATA_WIDTH-1:0] shbuf [DATA_NB-1];
  logic                  last_flag;
  logic                  up_xfer;
  logic                  down_xfer;

  assign up_ready  = rst_n & (rem == '0) & (~down_valid | down_ready);
  assign up_xfer   = up_valid & up_ready;
  assign down_xfer = down_valid & down_ready;

  // Out-of-range counts mean "full beat"; ord[] lists the words in emission order.
  always_comb begin
    n_eff = ((up_cnt == '0) || (up_cnt > NB_C)) ? NB_C : up_cnt;
    for (int k = 0; k < DATA_NB; k++) begin
      if (MSB_FIRST != 0) ord[k] = up_data[(DATA_NB-1-k)*DATA_WIDTH +: DATA_WIDTH];
      else                ord[k] = up_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rem        <= '0;
      last_flag  <= 1'b0;
      down_valid <= 1'b0;
      down_last  <= 1'b0;
      down_data  <= '0;
      for (int i = 0; i < DATA_NB-1; i++) shbuf[i] <= '0;
    end else if (up_xfer) begin
      down_valid <= 1'b1;
      down_data  <= ord[0];
      for (int i = 0; i < DATA_NB-1; i++) shbuf[i] <= ord[i+1];
      rem        <= n_eff - ONE_C;
      last_flag  <= up_last;
      down_last  <= up_last & (n_eff == ONE_C);
      state      <= (n_eff == ONE_C) ? TAIL : LOAD;
    end else if (down_xfer) begin
      if (state == LOAD || state == SHIFT) begin
        down_data <= shbuf[0];
        for (int i = 0; i < DATA_NB-2; i++) shbuf[i] <= shbuf[i+1];
        shbuf[DATA_NB-2] <= '0;
        rem       <= rem - ONE_C;
        down_last <= last_flag & (rem == ONE_C);
        state     <= (rem == ONE_C) ? TAIL : SHIFT;
      end else begin
        down_valid <= 1'b0;
        down_last  <= 1'b0;
        state      <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_axis_serializer_pkt.sv
// Directed bench for axis_serializer_pkt: LSB-first instance for the stream tests,
// MSB-first instance with its own reset for ordering and mid-beat reset.
module tb_axis_serializer_pkt;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        last;
    int          n;
    logic [7:0]  w [4];
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n  = 1'b0;
  logic rst_n1 = 1'b0;

  // LSB-first instance
  logic        up_ready, up_valid = 1'b0, up_last = 1'b0;
  logic [31:0] up_data = '0;
  logic [2:0]  up_cnt = '0;
  logic        down_ready = 1'b1, down_valid, down_last;
  logic [7:0]  down_data;

  // MSB-first instance
  logic        m_up_ready, m_up_valid = 1'b0, m_up_last = 1'b0;
  logic [31:0] m_up_data = '0;
  logic [2:0]  m_up_cnt = '0;
  logic        m_down_ready = 1'b1, m_down_valid, m_down_last;
  logic [7:0]  m_down_data;

  axis_serializer_pkt #(.DATA_NB(4), .DATA_WIDTH(8), .CNT_WIDTH(3), .MSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .up_ready(up_ready), .up_valid(up_valid), .up_data(up_data),
    .up_cnt(up_cnt), .up_last(up_last), .down_ready(down_ready), .down_valid(down_valid),
    .down_data(down_data), .down_last(down_last));

  axis_serializer_pkt #(.DATA_NB(4), .DATA_WIDTH(8), .CNT_WIDTH(3), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n1), .up_ready(m_up_ready), .up_valid(m_up_valid), .up_data(m_up_data),
    .up_cnt(m_up_cnt), .up_last(m_up_last), .down_ready(m_down_ready), .down_valid(m_down_valid),
    .down_data(m_down_data), .down_last(m_down_last));

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       bp_en  = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [8:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) down_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (hold_prev) begin
        check("bp_hold_data", 32'(down_data), 32'(prev_data));
        check("bp_hold_last", 32'(down_last), 32'(prev_last));
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {down_last, down_data});
        end else begin
          exp_w = exp_q.pop_front();
          check("stream_word", 32'({down_last, down_data}), 32'(exp_w));
        end
      end
      hold_prev = down_valid && !down_ready;
      prev_data = down_data;
      prev_last = down_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // driver: called at a negedge, returns at the negedge following acceptance
  task automatic send_beat(input logic [31:0] data, input logic [2:0] cnt, input logic last);
    logic got;
    got = 1'b0;
    up_valid = 1'b1;
    up_data  = data;
    up_cnt   = cnt;
    up_last  = last;
    for (int t = 0; t < 100 && !got; t++) begin
      #1;
      if (up_ready) got = 1'b1;
      @(negedge clk);
    end
    check("up_accept_timeout", 32'(got), 32'd1);
  endtask

  vec_t       vecs [8];
  logic [7:0] exp_sb [4];
  logic [7:0] exp_bb [8];

  initial begin
    vecs[0] = '{32'h44332211, 3'd4, 1'b1, 4, '{8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[1] = '{32'h44332211, 3'd2, 1'b1, 2, '{8'h11, 8'h22, 8'h00, 8'h00}};
    vecs[2] = '{32'h44332211, 3'd0, 1'b0, 4, '{8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[3] = '{32'h44332211, 3'd7, 1'b1, 4, '{8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[4] = '{32'h88776655, 3'd1, 1'b1, 1, '{8'h55, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{32'h88776655, 3'd3, 1'b0, 3, '{8'h55, 8'h66, 8'h77, 8'h00}};
    vecs[6] = '{32'hDDCCBBAA, 3'd5, 1'b1, 4, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}};
    vecs[7] = '{32'h0F1E2D3C, 3'd1, 1'b0, 1, '{8'h3C, 8'h00, 8'h00, 8'h00}};
    exp_sb = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_bb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // reset held with up_valid asserted
    up_valid = 1'b1; up_data = 32'hFFFFFFFF; up_cnt = 3'd4; up_last = 1'b1;
    m_up_valid = 1'b1; m_up_data = 32'hFFFFFFFF; m_up_cnt = 3'd4;
    repeat (3) begin
      @(negedge clk); #2;
      check("rst_up_ready", 32'(up_ready), 0);
      check("rst_down_valid", 32'(down_valid), 0);
      check("rst_down_last", 32'(down_last), 0);
      check("rst_down_data", 32'(down_data), 0);
      check("rst_m_up_ready", 32'(m_up_ready), 0);
    end
    @(negedge clk);
    rst_n = 1'b1; rst_n1 = 1'b1; up_valid = 1'b0; m_up_valid = 1'b0;
    @(negedge clk); #2;
    check("rst_release_up_ready", 32'(up_ready), 1);
    check("rst_release_m_up_ready", 32'(m_up_ready), 1);
    check("rst_release_idle", 32'(down_valid), 0);

    // single beat: timing, order, last, up_ready low for three cycles
    @(negedge clk);
    up_valid = 1'b1; up_data = 32'h44332211; up_cnt = 3'd4; up_last = 1'b1;
    #1 check("sb_accept_ready", 32'(up_ready), 1);
    @(negedge clk);
    up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("sb_valid", 32'(down_valid), 1);
      check("sb_data", 32'(down_data), 32'(exp_sb[i]));
      check("sb_last", 32'(down_last), (i == 3) ? 1 : 0);
      check("sb_up_ready", 32'(up_ready), (i == 3) ? 1 : 0);
      @(negedge clk);
    end
    #2 check("sb_idle", 32'(down_valid), 0);

    // back-to-back beats: continuous output, second accept on the 0x44 transfer
    @(negedge clk);
    up_valid = 1'b1; up_data = 32'h44332211; up_cnt = 3'd4; up_last = 1'b0;
    @(negedge clk);
    up_data = 32'h88776655; up_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) up_valid = 1'b0;
      #2;
      check("bb_valid", 32'(down_valid), 1);
      check("bb_data", 32'(down_data), 32'(exp_bb[i]));
      check("bb_last", 32'(down_last), (i == 7) ? 1 : 0);
      check("bb_up_ready", 32'(up_ready), (i == 3 || i == 7) ? 1 : 0);
      @(negedge clk);
    end
    #2 check("bb_idle", 32'(down_valid), 0);

    // table of beats: unstalled pass, then 50% backpressure pass with the same expectations
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      bp_en = (pass == 1);
      mon_en = 1'b1;
      foreach (vecs[v])
        for (int k = 0; k < vecs[v].n; k++)
          exp_q.push_back({vecs[v].last && (k == vecs[v].n - 1), vecs[v].w[k]});
      @(negedge clk);
      foreach (vecs[v]) send_beat(vecs[v].data, vecs[v].cnt, vecs[v].last);
      up_valid = 1'b0;
      for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(negedge clk);
      check("drain_remaining", 32'(exp_q.size()), 0);
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      bp_en = 1'b0;
      exp_q.delete();
    end

    // MSB-first ordering and reset in the middle of a beat
    @(negedge clk);
    m_up_valid = 1'b1; m_up_data = 32'h44332211; m_up_cnt = 3'd3; m_up_last = 1'b1;
    #1 check("msb_accept_ready", 32'(m_up_ready), 1);
    @(negedge clk);
    m_up_valid = 1'b0;
    #2;
    check("msb_w0", 32'({m_down_valid, m_down_last, m_down_data}), {16'h0, 2'b10, 8'h44});
    @(negedge clk); #2;
    check("msb_w1", 32'({m_down_valid, m_down_last, m_down_data}), {16'h0, 2'b10, 8'h33});
    rst_n1 = 1'b0;
    @(negedge clk); #2;
    check("msb_rst_valid", 32'(m_down_valid), 0);
    check("msb_rst_data", 32'(m_down_data), 0);
    check("msb_rst_up_ready", 32'(m_up_ready), 0);
    rst_n1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("msb_no_stale_word", 32'(m_down_valid), 0);
    end
    @(negedge clk);
    m_up_valid = 1'b1; m_up_data = 32'hDDCCBBAA; m_up_cnt = 3'd3; m_up_last = 1'b1;
    #1 check("msb2_accept_ready", 32'(m_up_ready), 1);
    @(negedge clk);
    m_up_valid = 1'b0;
    #2 check("msb2_w0", 32'({m_down_valid, m_down_last, m_down_data}), {16'h0, 2'b10, 8'hDD});
    @(negedge clk); #2;
    check("msb2_w1", 32'({m_down_valid, m_down_last, m_down_data}), {16'h0, 2'b10, 8'hCC});
    @(negedge clk); #2;
    check("msb2_w2", 32'({m_down_valid, m_down_last, m_down_data}), {16'h0, 2'b11, 8'hBB});
    @(negedge clk); #2;
    check("msb2_idle", 32'(m_down_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_serializer_pkt.md
Name: axis_serializer_pkt

Overview:
- Packet-aware, parametrised successor to the flow-bus serializer.
- Splits each wide 'up' beat of DATA_NB words into up to DATA_NB narrow 'down' words:
  - per-beat valid word count;
  - selectable word order;
  - packet-end (last) propagation.
- Uses a strict AXI-Stream handshake on both sides.
- Sits between wide internal datapaths (e.g. DMA read side) and narrow AXIS consumers.
- Sustains one down word per cycle, with no bubble between beats.

Parameters:
- DATA_NB, 4, words per up beat (>=2).
- DATA_WIDTH, 8, bits per down word.
- CNT_WIDTH, 3, width of up_cnt; must satisfy 2**CNT_WIDTH > DATA_NB.
- MSB_FIRST, 0, 0: emit word 0 (bits [DATA_WIDTH-1:0]) first; 1: emit word DATA_NB-1 first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- up_ready  out  1  block accepts up beat this cycle.
- up_valid  in  1  up beat present.
- up_data  in  DATA_WIDTH*DATA_NB  wide beat, word i at [i*DATA_WIDTH +: DATA_WIDTH].
- up_cnt  in  CNT_WIDTH  number of valid words in beat.
- up_last  in  1  beat ends a packet.
- down_ready  in  1  consumer accepts word.
- down_valid  out  1  word present.
- down_data  out  DATA_WIDTH  word.
- down_last  out  1  final word of a packet.

Behaviour:
- Decided: one clock (clk); reset rst_n is synchronous and active-low.
- Transfers: up transfer = up_valid & up_ready; down transfer = down_valid & down_ready.
- Reset (rst_n=0 at posedge): down_valid=0, down_last=0, down_data=0.
  - Internal remaining count rem=0; shift buffer cleared.
  - Any beat in progress is discarded.
  - up_ready=0 while rst_n=0.
- Word count: effective count n = up_cnt.
  - up_cnt==0 or up_cnt>DATA_NB is treated as n=DATA_NB.
- Order:
  - MSB_FIRST=0: words emitted 0,1,...,n-1.
  - MSB_FIRST=1: words emitted DATA_NB-1 down to DATA_NB-n.
  - Unused words are never emitted.
- Output stage: down_valid, down_data and down_last are registered.
  - While down_valid=1 and down_ready=0, all three hold stable.
- up_ready = rst_n & (rem==0) & (~down_valid | down_ready). Purely combinational from state and down_ready.
- On up transfer:
  - First word is loaded into down_data; down_valid<=1.
  - Remaining n-1 words are loaded into the shift buffer; rem<=n-1.
  - down_last <= up_last & (n==1).
- On down transfer with rem>0:
  - Next word is moved from the buffer to down_data; rem<=rem-1.
  - down_last <= stored last flag & (rem==1).
- On down transfer with rem==0 and no up transfer: down_valid<=0, down_last<=0.
- Latency: first word valid 1 cycle after up transfer.
- Throughput: back-to-back beats with down_ready held high give a continuous down_valid. The final word's down transfer and the next up transfer occur in the same cycle.
- State machine:
  - EMPTY (down_valid=0): -> LOAD on up transfer.
  - LOAD/SHIFT (down_valid=1, rem>0): -> SHIFT on down transfer while rem>1; -> TAIL when rem reaches 0.
  - TAIL (down_valid=1, rem==0): -> LOAD on simultaneous up transfer; -> EMPTY on down transfer alone.
- Stored last flag: latched on up transfer only; ignored if the beat is empty of further words.
- up_data, up_cnt and up_last are don't-care when no up transfer occurs.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with up_valid=1 -> up_ready=0, down_valid=0, down_last=0, down_data=0. Release -> up_ready=1 next cycle.
- Single beat:
  - Stimulus: DATA_NB=4, MSB_FIRST=0, up_data=0x44332211, up_cnt=4, up_last=1, down_ready=1.
  - Response: down_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; down_last=1 only with 0x44; up_ready low for 3 cycles.
- Back-to-back:
  - Stimulus: beats 0x44332211 (last=0) and 0x88776655 (last=1), up_valid continuous, down_ready=1.
  - Response: 8 contiguous valid words 0x11..0x88; second accept coincides with 0x44 transfer; down_last only on 0x88.
- Partial and clamped counts:
  - up_cnt=2 on 0x44332211 -> only 0x11,0x22 emitted, with last on 0x22 when up_last=1.
  - up_cnt=0 or up_cnt=7 -> all 4 words emitted.
- Backpressure: down_ready random at 50% -> down_data/down_last stable while down_valid & ~down_ready; output sequence identical to the unstalled run; no word lost or duplicated.
- MSB_FIRST=1 and mid-beat reset:
  - up_data=0x44332211, cnt=3 -> 0x44,0x33,0x22.
  - rst_n=0 after the second word -> down_valid=0 next cycle; the third word is never emitted; the next beat starts cleanly.
